// File: rtl/ercm_pkg.sv
// Shared types and constants for the approximate-multiplier error accumulator.
package ercm_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ercm_state_e;
endpackage

// File: rtl/ercm_ed_calc.sv
// Two-stage error-distance datapath: stage 1 registers the sample,
// stage 2 registers |a*b - p|. A flush drops both valid bits.
module ercm_ed_calc
  import ercm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [OP_W-1:0]   dat_a,
  input  logic [OP_W-1:0]   dat_b,
  input  logic [PROD_W-1:0] dat_p,
  output logic              s1_vld,
  output logic              ed_vld,
  output logic [PROD_W-1:0] ed
);
  logic              s1_vld_q, s1_vld_d;
  logic [OP_W-1:0]   s1_a_q, s1_a_d;
  logic [OP_W-1:0]   s1_b_q, s1_b_d;
  logic [PROD_W-1:0] s1_p_q, s1_p_d;
  logic              s2_vld_q, s2_vld_d;
  logic [PROD_W-1:0] s2_ed_q, s2_ed_d;
  logic [PROD_W-1:0] exact;

  always_comb begin
    s1_vld_d = in_vld & ~flush;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_p_d   = s1_p_q;
    if (in_vld) begin
      s1_a_d = dat_a;
      s1_b_d = dat_b;
      s1_p_d = dat_p;
    end
    // 8x8 unsigned product always fits in 16 bits
    exact    = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
    s2_vld_d = s1_vld_q & ~flush;
    s2_ed_d  = s2_ed_q;
    if (s1_vld_q) begin
      s2_ed_d = (exact >= s1_p_q) ? (exact - s1_p_q) : (s1_p_q - exact);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_p_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_ed_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_p_q   <= s1_p_d;
      s2_vld_q <= s2_vld_d;
      s2_ed_q  <= s2_ed_d;
    end
  end

  assign s1_vld = s1_vld_q;
  assign ed_vld = s2_vld_q;
  assign ed     = s2_ed_q;
endmodule

// File: rtl/ercm_err_acc.sv
// Windowed error statistics for an approximate multiplier.
// ERCM_ERR_ACC_MAX_EN enables the ed_max tracker; otherwise ed_max is 0.
// Handshake: a sample transfers on a rising edge where in_vld & in_rdy;
// in_rdy never depends on in_vld and there is no stall after transfer.
module ercm_err_acc
  import ercm_pkg::*;
#(
  parameter int WIN_W = 16,
  parameter int SUM_W = WIN_W + 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [OP_W-1:0]   dat_in_a,
  input  logic [OP_W-1:0]   dat_in_b,
  input  logic [PROD_W-1:0] dat_in_p,
  output logic              busy,
  output logic              done,
  output logic [WIN_W-1:0]  smp_cnt,
  output logic [WIN_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  ed_sum,
  output logic [15:0]       ed_max,
  output logic [1:0]        dbg_state
);
  ercm_state_e        state_q, state_d;
  logic [WIN_W-1:0]   win_len_q, win_len_d;
  logic [WIN_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [WIN_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [WIN_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]   ed_sum_q, ed_sum_d;
  logic               clr;
  logic               flush;
  logic               accept;
  logic               s1_vld;
  logic               ed_vld;
  logic [PROD_W-1:0]  ed;

  assign in_rdy = (state_q == ST_RUN) && (acc_cnt_q < win_len_q);
  assign accept = in_vld & in_rdy;
  assign flush  = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  ercm_ed_calc u_ed_calc (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_vld (accept),
    .dat_a  (dat_in_a),
    .dat_b  (dat_in_b),
    .dat_p  (dat_in_p),
    .s1_vld (s1_vld),
    .ed_vld (ed_vld),
    .ed     (ed)
  );

  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    acc_cnt_d = acc_cnt_q;
    clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          win_len_d = win_len;
          acc_cnt_d = '0;
          clr       = 1'b1;
          state_d   = (win_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          acc_cnt_d = acc_cnt_q + WIN_W'(1);
          if (acc_cnt_q + WIN_W'(1) == win_len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // the last sample accumulates on the edge that clears stage 2
        if (abort) state_d = ST_IDLE;
        else if (!s1_vld && !ed_vld) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    smp_cnt_d = smp_cnt_q;
    err_cnt_d = err_cnt_q;
    ed_sum_d  = ed_sum_q;
    if (clr) begin
      smp_cnt_d = '0;
      err_cnt_d = '0;
      ed_sum_d  = '0;
    end else if (ed_vld) begin
      smp_cnt_d = smp_cnt_q + WIN_W'(1);
      ed_sum_d  = ed_sum_q + SUM_W'(ed);
      if (ed != '0) err_cnt_d = err_cnt_q + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_len_q <= '0;
      acc_cnt_q <= '0;
      smp_cnt_q <= '0;
      err_cnt_q <= '0;
      ed_sum_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_len_q <= win_len_d;
      acc_cnt_q <= acc_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      err_cnt_q <= err_cnt_d;
      ed_sum_q  <= ed_sum_d;
    end
  end

`ifdef ERCM_ERR_ACC_MAX_EN
  logic [15:0] ed_max_q, ed_max_d;

  always_comb begin
    ed_max_d = ed_max_q;
    if (clr) ed_max_d = '0;
    else if (ed_vld && (ed > ed_max_q)) ed_max_d = ed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ed_max_q <= '0;
    else     ed_max_q <= ed_max_d;
  end

  assign ed_max = ed_max_q;
`else
  assign ed_max = '0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign smp_cnt   = smp_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign ed_sum    = ed_sum_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ercm_err_acc.sv
// Directed bench for ercm_err_acc with immediate-assertion checks.
module tb_ercm_err_acc;
  localparam int WIN_W = 16;
  localparam int SUM_W = WIN_W + 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [WIN_W-1:0]  win_len = '0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [7:0]        dat_in_a = '0;
  logic [7:0]        dat_in_b = '0;
  logic [15:0]       dat_in_p = '0;
  logic              busy;
  logic              done;
  logic [WIN_W-1:0]  smp_cnt;
  logic [WIN_W-1:0]  err_cnt;
  logic [SUM_W-1:0]  ed_sum;
  logic [15:0]       ed_max;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;

`ifdef ERCM_ERR_ACC_MAX_EN
  localparam logic [15:0] EXP_MAX_030 = 16'd8;
`else
  localparam logic [15:0] EXP_MAX_030 = 16'd0;
`endif

  ercm_err_acc #(.WIN_W(WIN_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .win_len   (win_len),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .dat_in_a  (dat_in_a),
    .dat_in_b  (dat_in_b),
    .dat_in_p  (dat_in_p),
    .busy      (busy),
    .done      (done),
    .smp_cnt   (smp_cnt),
    .err_cnt   (err_cnt),
    .ed_sum    (ed_sum),
    .ed_max    (ed_max),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    bit ok = 1'b0;
    in_vld   = 1'b1;
    dat_in_a = a;
    dat_in_b = b;
    dat_in_p = p;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_rdy) ok = 1'b1;
      tick();
    end
    in_vld = 1'b0;
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    int acc;
    int dn;
    bit rdy_seen;

    // reset state
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(in_rdy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_smp", 64'(smp_cnt), 64'd0);
    chk("rst_sum", 64'(ed_sum), 64'd0);
    chk("rst_max", 64'(ed_max), 64'd0);
    rst = 1'b0;
    tick();

    // single exact sample, latency check
    win_len = 16'd1; start = 1'b1;
    in_vld = 1'b1; dat_in_a = 8'd3; dat_in_b = 8'd5; dat_in_p = 16'd15;
    tick();
    start = 1'b0;
    chk("w1_rdy_run", 64'(in_rdy), 64'd1);
    tick();
    in_vld = 1'b0;
    chk("w1_rdy_after", 64'(in_rdy), 64'd0);
    chk("w1_done_a", 64'(done), 64'd0);
    tick();
    chk("w1_done_b", 64'(done), 64'd0);
    tick();
    chk("w1_smp_vis", 64'(smp_cnt), 64'd1);
    chk("w1_done_c", 64'(done), 64'd0);
    tick();
    chk("w1_done", 64'(done), 64'd1);
    chk("w1_err", 64'(err_cnt), 64'd0);
    chk("w1_sum", 64'(ed_sum), 64'd0);
    chk("w1_max", 64'(ed_max), 64'd0);
    tick();
    chk("w1_done_end", 64'(done), 64'd0);
    chk("w1_busy_end", 64'(busy), 64'd0);
    chk("w1_hold", 64'(smp_cnt), 64'd1);

    // three samples with mixed errors
    win_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("w3_clear", 64'(smp_cnt), 64'd0);
    send(8'd255, 8'd255, 16'd65024);
    send(8'd16, 8'd16, 16'd256);
    send(8'd7, 8'd9, 16'd55);
    chk("w3_rdy_after", 64'(in_rdy), 64'd0);
    wait_done();
    chk("w3_smp", 64'(smp_cnt), 64'd3);
    chk("w3_err", 64'(err_cnt), 64'd2);
    chk("w3_sum", 64'(ed_sum), 64'd9);
    chk("w3_max", 64'(ed_max), 64'(EXP_MAX_030));
    tick();

    // in_vld toggling every other cycle
    win_len = 16'd4; start = 1'b1;
    dat_in_a = 8'd1; dat_in_b = 8'd1; dat_in_p = 16'd1;
    tick();
    start = 1'b0;
    acc = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      in_vld = (i % 2 == 0);
      if (i == 1) chk("w4_rdy_no_vld", 64'(in_rdy), 64'd1);
      if (in_vld && in_rdy) acc++;
      tick();
      if (done) dn++;
    end
    in_vld = 1'b0;
    chk("w4_accepts", 64'(acc), 64'd4);
    chk("w4_dones", 64'(dn), 64'd1);
    chk("w4_smp", 64'(smp_cnt), 64'd4);

    // zero-length window
    win_len = 16'd0; start = 1'b1;
    rdy_seen = 1'b0; dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (in_rdy) rdy_seen = 1'b1;
      tick();
      start = 1'b0;
      if (done) dn++;
    end
    chk("w0_dones", 64'(dn), 64'd1);
    chk("w0_rdy", 64'(rdy_seen), 64'd0);
    chk("w0_smp", 64'(smp_cnt), 64'd0);
    chk("w0_sum", 64'(ed_sum), 64'd0);

    // abort after five accepts, start in RUN ignored
    win_len = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    send(8'd2, 8'd2, 16'd5);
    send(8'd2, 8'd2, 16'd5);
    start = 1'b1; win_len = 16'd2;
    send(8'd2, 8'd2, 16'd5);
    start = 1'b0;
    chk("ab_start_ignored", 64'(in_rdy), 64'd1);
    send(8'd2, 8'd2, 16'd5);
    send(8'd2, 8'd2, 16'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_state", 64'(dbg_state), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_rdy", 64'(in_rdy), 64'd0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dn++;
    end
    chk("ab_no_done", 64'(dn), 64'd0);
    chk("ab_smp_range", 64'(smp_cnt >= 3 && smp_cnt <= 5), 64'd1);
    chk("ab_err_eq_smp", 64'(err_cnt), 64'(smp_cnt));

    // asynchronous reset mid-RUN
    win_len = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    send(8'd2, 8'd2, 16'd5);
    send(8'd2, 8'd2, 16'd5);
    tick();
    tick();
    chk("rr_pre_smp", 64'(smp_cnt), 64'd2);
    chk("rr_pre_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_rdy", 64'(in_rdy), 64'd0);
    chk("rr_smp", 64'(smp_cnt), 64'd0);
    chk("rr_err", 64'(err_cnt), 64'd0);
    chk("rr_sum", 64'(ed_sum), 64'd0);
    chk("rr_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ercm_err_acc.md
ERCM_ERR_ACC -- requirements
Module: ercm_err_acc

Interface
REQ-001 SHALL have parameter WIN_W, default 16, meaning sample-counter and window-length width.
REQ-002 SHALL have parameter SUM_W, default WIN_W+16, meaning error-distance accumulator width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  begin a measurement window (sampled in IDLE only).
REQ-006 SHALL have port abort  in  1  terminate current window.
REQ-007 SHALL have port win_len  in  WIN_W  number of samples per window, latched on start.
REQ-008 SHALL have port in_vld  in  1  sample valid.
REQ-009 SHALL have port in_rdy  out  1  sample accepted when in_vld & in_rdy.
REQ-010 SHALL have ports dat_in_a, dat_in_b  in  8 each  multiplier operands of the sample.
REQ-011 SHALL have port dat_in_p  in  16  approximate product from the approximate multiplier for those operands.
REQ-012 SHALL have ports busy  out  1  (state != IDLE), done  out  1  one-cycle end-of-window pulse.
REQ-013 SHALL have ports smp_cnt  out  WIN_W, err_cnt  out  WIN_W, ed_sum  out  SUM_W, ed_max  out  16: accumulated results.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE & start: latch win_len, clear smp_cnt/err_cnt/ed_sum/ed_max, go RUN; if win_len==0 go DONE instead.
REQ-016 in_rdy SHALL be 1 only in RUN while accepted-sample count < latched win_len; combinationally independent of in_vld.
REQ-017 Accepted sample SHALL enter stage 1 (register operands, exact product a*b, 16 bit unsigned) then stage 2 (ED = |exact - dat_in_p|, 16 bit).
REQ-018 Accumulate stage SHALL, one cycle after stage 2 valid: smp_cnt+1, ed_sum+ED, err_cnt+1 if ED!=0, ed_max=max(ed_max,ED); sample visible in outputs 3 cycles after acceptance.
REQ-019 ed_sum SHALL not saturate; SUM_W guarantees 65025*(2^WIN_W-1) fits.
REQ-020 RUN → DRAIN on the cycle the win_len-th sample is accepted; DRAIN → DONE when both pipeline valid bits are 0 and last sample accumulated.
REQ-021 DONE SHALL last exactly one cycle with done=1, then IDLE; results held until next start or rst.
REQ-022 start outside IDLE SHALL be ignored; abort in RUN/DRAIN SHALL go IDLE next cycle, clear pipeline valid bits, no done pulse, results keep partial values.
REQ-023 abort and start in the same IDLE cycle: abort wins, start ignored.
REQ-024 Back-pressure-free: no input stall once accepted; in_vld may drop any cycle without loss.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, in_rdy=0, busy=0, done=0, all counters/accumulators/ed_max=0, pipeline valid bits 0; mid-window reset discards in-flight samples.

Configuration
REQ-026 Macro ERCM_ERR_ACC_MAX_EN defined: ed_max tracked per REQ-018; undefined: ed_max tied to 0 and its comparator/register not built.

Structure
REQ-027 Package ercm_pkg SHALL hold the state enum type, OP_W=8, PROD_W=16 constants.
REQ-028 Sub-module ercm_ed_calc SHALL compute exact product and absolute error distance (stages 1-2); FSM and accumulators stay in ercm_err_acc.

Verification
REQ-029 win_len=1, sample a=3,b=5,p=15 -> done 4 cycles after accept; smp_cnt=1, err_cnt=0, ed_sum=0, ed_max=0.
REQ-030 win_len=3, samples (255,255,p=65024),(16,16,p=256),(7,9,p=55) -> err_cnt=2, ed_sum=9, ed_max=8, in_rdy=0 after third accept.
REQ-031 win_len=4 with in_vld toggling every other cycle -> exactly 4 accepts, single done pulse, smp_cnt=4.
REQ-032 win_len=0, start -> done next-but-one cycle, all results 0, in_rdy never 1.
REQ-033 win_len=8, abort after 5 accepts -> IDLE next cycle, no done, smp_cnt<=5 reflecting only accumulated samples; start in RUN ignored.
REQ-034 rst asserted mid-RUN (async, between edges) -> outputs 0 immediately; build without ERCM_ERR_ACC_MAX_EN -> ed_max=0 for REQ-030 stimulus.
